// File: rtl/serial_byte_deframer.sv
// -----------------------------------------------------------------------------
// serial_byte_deframer
// Assembles a framed serial bitstream into a parallel word, optionally checks a
// trailing parity bit, and hands the word downstream over a valid/ready
// handshake. Feeds the d bus and load strobe of the 8-bit data latch.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   sin          serial data bit
//   sin_valid    sin is valid this cycle
//   frame_start  marks sin as the first data bit of a frame
//   d            assembled word, first received bit lands in d[0]
//   out_valid    d holds a completed, unconsumed word
//   out_ready    downstream can take the word
//   latch_en     out_valid & out_ready, load strobe for the latch
//   parity_err   parity mismatch for the word on d (meaningful while out_valid)
//   framing_err  one-cycle pulse when a frame is aborted by an early frame_start
//   overrun      sticky flag: a bit arrived while a word was being held
// -----------------------------------------------------------------------------
module serial_byte_deframer #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [0:WIDTH-1] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             latch_en,
  output logic             parity_err,
  output logic             framing_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_LOAD   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t           state_r, state_next_s;
  logic [0:WIDTH-1] shreg_r, shreg_next_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic             perr_r, perr_next_s;
  logic [0:WIDTH-1] d_r, d_next_s;
  logic             out_valid_r, out_valid_next_s;
  logic             parity_err_r, parity_err_next_s;
  logic             framing_err_r, framing_err_next_s;
  logic             overrun_r, overrun_next_s;

  // Parity mismatch: XOR of data and parity bit must equal the selected sense.
  function automatic logic calc_perr(input logic [0:WIDTH-1] data, input logic pbit);
    return ((^data) ^ pbit) != (PARITY_ODD != 0);
  endfunction

  // Returns data with the bit at position idx replaced by b.
  function automatic logic [0:WIDTH-1] put_bit(input logic [0:WIDTH-1] data,
                                               input logic [CW-1:0]    idx,
                                               input logic             b);
    logic [0:WIDTH-1] res;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CW'(i)) begin
        res[i] = b;
      end else begin
        res[i] = data[i];
      end
    end
    return res;
  endfunction

  // Next-state and next-value logic for the deframer FSM and its datapath.
  always_comb begin
    state_next_s       = state_r;
    shreg_next_s       = shreg_r;
    cnt_next_s         = cnt_r;
    perr_next_s        = perr_r;
    d_next_s           = d_r;
    out_valid_next_s   = out_valid_r;
    parity_err_next_s  = parity_err_r;
    framing_err_next_s = 1'b0;
    overrun_next_s     = overrun_r;

    case (state_r)
      ST_IDLE: begin
        // Bits without frame_start are ignored while idle.
        if (sin_valid && frame_start) begin
          shreg_next_s = put_bit(shreg_r, CW'(0), sin);
          cnt_next_s   = CW'(1);
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (sin_valid && frame_start) begin
          // Abort: the same bit restarts a fresh frame.
          framing_err_next_s = 1'b1;
          shreg_next_s       = put_bit(shreg_r, CW'(0), sin);
          cnt_next_s         = CW'(1);
          state_next_s       = ST_SHIFT;
        end else if (sin_valid) begin
          shreg_next_s = put_bit(shreg_r, cnt_r, sin);
          cnt_next_s   = cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_next_s = (PARITY_EN != 0) ? ST_PARITY : ST_LOAD;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_SHIFT;
        end
      end

      ST_PARITY: begin
        if (sin_valid && frame_start) begin
          framing_err_next_s = 1'b1;
          shreg_next_s       = put_bit(shreg_r, CW'(0), sin);
          cnt_next_s         = CW'(1);
          state_next_s       = ST_SHIFT;
        end else if (sin_valid) begin
          perr_next_s  = calc_perr(shreg_r, sin);
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_PARITY;
        end
      end

      ST_LOAD: begin
        d_next_s          = shreg_r;
        parity_err_next_s = (PARITY_EN != 0) ? perr_r : 1'b0;
        out_valid_next_s  = 1'b1;
        state_next_s      = ST_HOLD;
        // A bit here would be lost just like in HOLD.
        if (sin_valid) begin
          overrun_next_s = 1'b1;
        end else begin
          overrun_next_s = overrun_r;
        end
      end

      ST_HOLD: begin
        if (sin_valid) begin
          overrun_next_s = 1'b1;
        end else begin
          overrun_next_s = overrun_r;
        end
        if (out_ready) begin
          out_valid_next_s = 1'b0;
          state_next_s     = ST_IDLE;
        end else begin
          out_valid_next_s = 1'b1;
          state_next_s     = ST_HOLD;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      shreg_r       <= '0;
      cnt_r         <= '0;
      perr_r        <= 1'b0;
      d_r           <= '0;
      out_valid_r   <= 1'b0;
      parity_err_r  <= 1'b0;
      framing_err_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      shreg_r       <= shreg_next_s;
      cnt_r         <= cnt_next_s;
      perr_r        <= perr_next_s;
      d_r           <= d_next_s;
      out_valid_r   <= out_valid_next_s;
      parity_err_r  <= parity_err_next_s;
      framing_err_r <= framing_err_next_s;
      overrun_r     <= overrun_next_s;
    end
  end

  assign d           = d_r;
  assign out_valid   = out_valid_r;
  assign parity_err  = parity_err_r;
  assign framing_err = framing_err_r;
  assign overrun     = overrun_r;
  // The latch strobe must follow out_ready in the same cycle.
  assign latch_en    = out_valid_r & out_ready;

endmodule

// File: tb/tb_serial_byte_deframer.sv
// -----------------------------------------------------------------------------
// tb_serial_byte_deframer
// Directed self-checking bench for serial_byte_deframer (WIDTH=8, even parity).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_serial_byte_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       frame_start;
  logic [0:7] d;
  logic       out_valid;
  logic       out_ready;
  logic       latch_en;
  logic       parity_err;
  logic       framing_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  serial_byte_deframer #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .d           (d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .latch_en    (latch_en),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of serial input and advance to the next falling edge.
  task automatic drive(input logic v, input logic f, input logic s);
    sin_valid   = v;
    frame_start = f;
    sin         = s;
    @(negedge clk);
  endtask

  // Send a full frame: 8 data bits (first with frame_start) plus parity bit.
  task automatic send_word(input logic [0:7] w, input logic p, input logic gap);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), w[i]);
      if (gap) begin
        drive(1'b0, 1'b0, 1'b0);
      end
    end
    drive(1'b1, 1'b0, p);
  endtask

  initial begin
    logic [0:7] w;
    rst = 1'b1; out_ready = 1'b0;
    sin_valid = 1'b0; frame_start = 1'b0; sin = 1'b0;

    // 1: reset for two edges while inputs toggle
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("rst_d", d, 32'h00);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_parity_err", parity_err, 32'd0);
    chk("rst_framing_err", framing_err, 32'd0);
    chk("rst_overrun", overrun, 32'd0);
    chk("rst_latch_en", latch_en, 32'd0);
    rst = 1'b0;

    // Stray bits without frame_start in IDLE are ignored
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("idle_ignore_valid", out_valid, 32'd0);

    // 2: B6 with correct even parity, out_ready high
    out_ready = 1'b1;
    send_word(8'hB6, 1'b1, 1'b0);
    chk("t2_no_valid_at_parity", out_valid, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_out_valid", out_valid, 32'd1);
    chk("t2_d", d, 32'hB6);
    chk("t2_parity_err", parity_err, 32'd0);
    chk("t2_latch_en", latch_en, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_consumed", out_valid, 32'd0);
    chk("t2_latch_en_off", latch_en, 32'd0);
    chk("t2_d_kept", d, 32'hB6);

    // 3: same frame, wrong parity, idle gaps between bits
    send_word(8'hB6, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_out_valid", out_valid, 32'd1);
    chk("t3_d", d, 32'hB6);
    chk("t3_parity_err", parity_err, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_consumed", out_valid, 32'd0);
    chk("t3_no_overrun", overrun, 32'd0);

    // 4: 5A held with out_ready low, extra bits cause overrun
    out_ready = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_out_valid", out_valid, 32'd1);
    chk("t4_d", d, 32'h5A);
    chk("t4_parity_err", parity_err, 32'd0);
    chk("t4_latch_en_low", latch_en, 32'd0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("t4_overrun", overrun, 32'd1);
    chk("t4_d_stable", d, 32'h5A);
    chk("t4_still_valid", out_valid, 32'd1);
    sin_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t4_latch_en", latch_en, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_consumed", out_valid, 32'd0);
    chk("t4_overrun_sticky", overrun, 32'd1);

    // 5: abort after 4 bits, then C3 (parity 0)
    w = 8'hC3;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("t5_no_err_yet", framing_err, 32'd0);
    drive(1'b1, 1'b1, w[0]);
    chk("t5_framing_err", framing_err, 32'd1);
    chk("t5_no_valid", out_valid, 32'd0);
    drive(1'b1, 1'b0, w[1]);
    chk("t5_framing_pulse_end", framing_err, 32'd0);
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 1'b0, w[i]);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_out_valid", out_valid, 32'd1);
    chk("t5_d", d, 32'hC3);
    chk("t5_parity_err", parity_err, 32'd0);
    drive(1'b0, 1'b0, 1'b0);

    // 6a: reset during SHIFT
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6a_out_valid", out_valid, 32'd0);
    chk("t6a_d", d, 32'h00);
    chk("t6a_overrun", overrun, 32'd0);

    // 6b: reset during HOLD after an overrun
    out_ready = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("t6b_held", out_valid, 32'd1);
    chk("t6b_overrun_set", overrun, 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6b_out_valid", out_valid, 32'd0);
    chk("t6b_d", d, 32'h00);
    chk("t6b_overrun", overrun, 32'd0);

    // 6c: clean frame after reset
    out_ready = 1'b1;
    send_word(8'hB6, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t6c_out_valid", out_valid, 32'd1);
    chk("t6c_d", d, 32'hB6);
    chk("t6c_parity_err", parity_err, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t6c_consumed", out_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
